// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, grant index width, default tag base.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TAG   = 3'd1,
        S_SEND  = 3'd2,
        S_GUARD = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam int          GRANT_W      = 3;
    localparam logic [7:0]  TAG_BASE_DEF = 8'hF0;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first set bit of req scanning ptr+1, ptr+2, ... modulo N_REQ.
module uart_tx_arbiter_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] pick,
    output logic               any
);

    // Scan farthest position first so the nearest hit after ptr is the last assignment and wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
                    pick = GRANT_W'(i);
                    any  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between N_REQ byte streams, holding the grant until a LAST byte.
// Optional macro UART_TX_ARBITER_TAG_EN: prefix each change of owner with a tag byte TAG_BASE + index.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W_TIMEOUT = 16
`ifdef UART_TX_ARBITER_TAG_EN
    ,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_we,
    input  logic                 tx_ready,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 grant_vld,
    output logic                 timeout
);

    state_t                 state, state_nxt;
    logic [GRANT_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [W_TIMEOUT-1:0]   stall_cnt, stall_nxt, stall_inc;
    logic                   last_q, last_nxt;
    logic [7:0]             tx_data_nxt;
    logic                   tx_we_nxt, grant_vld_nxt, timeout_nxt;
    logic [GRANT_W-1:0]     grant_id_nxt;
    logic [GRANT_W-1:0]     pick;
    logic                   any;
    logic                   cur_valid, cur_last, accept;
    logic [7:0]             cur_byte;
`ifdef UART_TX_ARBITER_TAG_EN
    logic [GRANT_W-1:0]     last_owner, last_owner_nxt;
    logic                   owner_vld, owner_vld_nxt;
`endif

    uart_tx_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == GRANT_W'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_byte  = req_data[8*i +: 8];
            end
        end
    end

    assign accept    = (state == S_SEND) && tx_ready && cur_valid;
    assign stall_inc = stall_cnt + W_TIMEOUT'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept && (grant_id == GRANT_W'(i));
        end
    end

    always_comb begin
        state_nxt     = state;
        tx_data_nxt   = tx_data;
        tx_we_nxt     = 1'b0;
        grant_id_nxt  = grant_id;
        grant_vld_nxt = grant_vld;
        timeout_nxt   = 1'b0;
        rr_ptr_nxt    = rr_ptr;
        stall_nxt     = stall_cnt;
        last_nxt      = last_q;
`ifdef UART_TX_ARBITER_TAG_EN
        last_owner_nxt = last_owner;
        owner_vld_nxt  = owner_vld;
`endif
        case (state)
            S_IDLE: begin
                if (any) begin
                    grant_id_nxt  = pick;
                    grant_vld_nxt = 1'b1;
`ifdef UART_TX_ARBITER_TAG_EN
                    state_nxt      = (!owner_vld || pick != last_owner) ? S_TAG : S_SEND;
                    last_owner_nxt = pick;
                    owner_vld_nxt  = 1'b1;
`else
                    state_nxt = S_SEND;
`endif
                end
            end
`ifdef UART_TX_ARBITER_TAG_EN
            S_TAG: begin
                if (tx_ready) begin
                    tx_data_nxt = TAG_BASE + 8'(grant_id);
                    tx_we_nxt   = 1'b1;
                    last_nxt    = 1'b0;
                    state_nxt   = S_GUARD;
                end
            end
`endif
            S_SEND: begin
                if (accept) begin
                    tx_data_nxt = cur_byte;
                    tx_we_nxt   = 1'b1;
                    last_nxt    = cur_last;
                    stall_nxt   = '0;
                    state_nxt   = S_GUARD;
                end else if (!cur_valid) begin
                    // Owner went quiet mid-packet: give the UART away after the stall budget.
                    if (stall_inc == {W_TIMEOUT{1'b1}}) begin
                        timeout_nxt   = 1'b1;
                        grant_vld_nxt = 1'b0;
                        rr_ptr_nxt    = grant_id;
                        stall_nxt     = '0;
                        state_nxt     = S_IDLE;
                    end else begin
                        stall_nxt = stall_inc;
                    end
                end
            end
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (tx_ready) begin
                    if (last_q) begin
                        rr_ptr_nxt    = grant_id;
                        grant_vld_nxt = 1'b0;
                        state_nxt     = S_IDLE;
                    end else begin
                        state_nxt = S_SEND;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            tx_data   <= '0;
            tx_we     <= 1'b0;
            grant_id  <= '0;
            grant_vld <= 1'b0;
            timeout   <= 1'b0;
            rr_ptr    <= GRANT_W'(N_REQ - 1);
            stall_cnt <= '0;
            last_q    <= 1'b0;
`ifdef UART_TX_ARBITER_TAG_EN
            last_owner <= '0;
            owner_vld  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            tx_data   <= tx_data_nxt;
            tx_we     <= tx_we_nxt;
            grant_id  <= grant_id_nxt;
            grant_vld <= grant_vld_nxt;
            timeout   <= timeout_nxt;
            rr_ptr    <= rr_ptr_nxt;
            stall_cnt <= stall_nxt;
            last_q    <= last_nxt;
`ifdef UART_TX_ARBITER_TAG_EN
            last_owner <= last_owner_nxt;
            owner_vld  <= owner_vld_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART busy model, per-requester byte queues, packet-level reference.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int WT    = 6;
    localparam int FRAME = 8;
    localparam int DEPTH = 8192;

    logic             CLK = 1'b0;
    logic             RST;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_we;
    logic             tx_ready;
    logic [2:0]       grant_id;
    logic             grant_vld;
    logic             timeout;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.N_REQ(N), .W_TIMEOUT(WT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_we     (tx_we),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    // UART stand-in: READY drops the cycle after WE and stays low for FRAME cycles; not reset by RST.
    int busy = 0;
    int cyc  = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (tx_we) busy <= FRAME;
        else if (busy > 0) busy <= busy - 1;
    end
    assign tx_ready = (busy == 0);

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [8:0]  mem [N][DEPTH];
    int          head [N];
    int          tail [N];
    logic [7:0]  got_b[$];
    logic [2:0]  got_o[$];
    int          we_cyc[$];
    int          to_cyc[$];
    logic        to_gv;
    logic [7:0]  exp_b[$];
    logic [2:0]  exp_o[$];
    int          acc_cnt [N];
    logic [N-1:0] acc_lat = '0;
    int          we_bad = 0;
    int          onehot_bad = 0;
    int          m_ptr = N - 1;
    int          m_owner = -1;

    always @(negedge CLK) begin
        acc_lat <= '0;
        if (!RST) begin
            if (tx_we) begin
                got_b.push_back(tx_data);
                got_o.push_back(grant_id);
                we_cyc.push_back(cyc);
                if (busy != 0) we_bad <= we_bad + 1;
            end
            if (timeout) begin
                to_cyc.push_back(cyc);
                to_gv <= grant_vld;
            end
            if ($countones(req_ready) > 1) onehot_bad <= onehot_bad + 1;
            for (int i = 0; i < N; i++) if (req_ready[i]) acc_cnt[i] <= acc_cnt[i] + 1;
            acc_lat <= req_ready;
        end
    end

    // Requester side: present queue heads, pop the one accepted in the previous cycle.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_lat[i] && head[i] < tail[i]) head[i] = head[i] + 1;
                if (head[i] < tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = mem[i][head[i]][7:0];
                    req_last[i]        = mem[i][head[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    task automatic load(input int r, input logic [7:0] b, input logic last);
        mem[r][tail[r]] = {last, b};
        tail[r] = tail[r] + 1;
    endtask

    function automatic void emit_owner(input int r);
`ifdef UART_TX_ARBITER_TAG_EN
        if (m_owner != r) begin
            exp_b.push_back(8'hF0 + 8'(r));
            exp_o.push_back(3'(r));
        end
`endif
        m_owner = r;
    endfunction

    // Whole packets leave in round-robin order after the previous owner, never interleaved.
    function automatic void model_schedule();
        int p [N];
        int sel;
        logic [8:0] w;
        for (int i = 0; i < N; i++) p[i] = head[i];
        while (1) begin
            sel = -1;
            for (int k = 1; k <= N; k++) begin
                if (sel < 0 && p[(m_ptr + k) % N] < tail[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
            end
            if (sel < 0) break;
            emit_owner(sel);
            do begin
                w = mem[sel][p[sel]];
                exp_b.push_back(w[7:0]);
                exp_o.push_back(3'(sel));
                p[sel] = p[sel] + 1;
            end while (!w[8] && p[sel] < tail[sel]);
            m_ptr = sel;
        end
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge CLK);
            done = tx_ready && !grant_vld;
            for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 0;
        end
        if (!done) check_eq({tag, "_drain"}, 0, 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (got_b.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (got_b.size() < n) check_eq({tag, "_bytes_wait"}, got_b.size(), n);
    endtask

    task automatic compare_streams(input string tag);
        int n;
        check_eq({tag, "_count"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_byte"}, got_b[i], exp_b[i]);
            check_eq({tag, "_owner"}, got_o[i], exp_o[i]);
        end
        got_b.delete(); got_o.delete(); exp_b.delete(); exp_o.delete(); we_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_we"}, tx_we, 0);
        check_eq({tag, "_data"}, tx_data, 0);
        check_eq({tag, "_gid"}, grant_id, 0);
        check_eq({tag, "_gvld"}, grant_vld, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
        check_eq({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < N; i++) head[i] = tail[i];
        got_b.delete(); got_o.delete(); exp_b.delete(); exp_o.delete(); we_cyc.delete();
        m_ptr = N - 1;
        m_owner = -1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    int lc, t_we, nb;
    logic [7:0] rb;

    initial begin
        RST = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; acc_cnt[i] = 0; end
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // 1: single three-byte packet on req0
        lc = cyc;
        load(0, 8'h11, 0); load(0, 8'h22, 0); load(0, 8'h33, 1);
        model_schedule();
        wait_drain("t1", 500);
        if (we_cyc.size() > 0) check_eq("t1_latency", we_cyc[0] - lc, 3);
        else check_eq("t1_latency_nowe", 0, 1);
        check_eq("t1_accepts", acc_cnt[0], 3);
        check_eq("t1_gvld_end", grant_vld, 0);
        compare_streams("t1");

        // 2: simultaneous req0/req2, then req1/req2 contention
        @(negedge CLK);
        load(0, 8'hA0, 0); load(0, 8'hA1, 1);
        load(2, 8'hB0, 1);
        model_schedule();
        wait_drain("t2a", 500);
        compare_streams("t2a");
        @(negedge CLK);
        load(1, 8'hC0, 1);
        load(2, 8'hD0, 0); load(2, 8'hD1, 1);
        model_schedule();
        wait_drain("t2b", 500);
        compare_streams("t2b");

        // 3: req1 stalls mid-packet; lock dropped after the stall budget, req3 takes over
        to_cyc.delete();
        @(negedge CLK);
        load(1, 8'h5A, 0);
        emit_owner(1);
        exp_b.push_back(8'h5A);
        exp_o.push_back(3'd1);
        m_ptr = 1;
        wait_bytes("t3", exp_b.size(), 500);
        t_we = (we_cyc.size() > 0) ? we_cyc[$] : 0;
        load(3, 8'h77, 1);
        model_schedule();
        for (int k = 0; k < 500 && to_cyc.size() == 0; k++) @(negedge CLK);
        if (to_cyc.size() > 0) begin
            check_eq("t3_timeout_delay", to_cyc[0] - t_we, FRAME + (1 << WT) + 1);
            check_eq("t3_gvld_at_timeout", to_gv, 0);
        end else check_eq("t3_timeout_seen", 0, 1);
        wait_drain("t3", 500);
        check_eq("t3_timeout_count", to_cyc.size(), 1);
        compare_streams("t3");

        // 4: reset while waiting for the UART, then a clean packet
        @(negedge CLK);
        load(0, 8'h01, 0); load(0, 8'h02, 0); load(0, 8'h03, 1);
        wait_bytes("t4", 1, 500);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("t4_async");
        RST = 1'b0;
        do_reset();
        @(negedge CLK);
        load(2, 8'hE0, 0); load(2, 8'hE1, 1);
        model_schedule();
        wait_drain("t4", 500);
        compare_streams("t4");

`ifdef UART_TX_ARBITER_TAG_EN
        // 5: tags only on owner change
        do_reset();
        @(negedge CLK);
        load(2, 8'hAA, 0); load(2, 8'hBB, 1); load(2, 8'hCC, 1);
        model_schedule();
        wait_drain("t5a", 500);
        check_eq("t5a_tag", (got_b.size() > 0) ? got_b[0] : 8'h00, 8'hF2);
        compare_streams("t5a");
        @(negedge CLK);
        load(0, 8'hDD, 1);
        model_schedule();
        wait_drain("t5b", 500);
        check_eq("t5b_tag", (got_b.size() > 0) ? got_b[0] : 8'h00, 8'hF0);
        compare_streams("t5b");
`endif

        // 6: 1000 random packets from random requesters
        @(negedge CLK);
        for (int p = 0; p < 1000; p++) begin
            int r;
            r = $urandom_range(N - 1, 0);
            nb = $urandom_range(4, 1);
            for (int b = 0; b < nb; b++) begin
                rb = 8'($urandom);
                load(r, rb, (b == nb - 1));
            end
        end
        model_schedule();
        wait_drain("t6", 80000);
        compare_streams("t6");

        check_eq("we_while_busy", we_bad, 0);
        check_eq("ready_onehot", onehot_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
